// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside execute; result feeds the mul_read write-back path.
// Latency: 33 cycles launch-to-done (radix-2, 32 iterations); div-by-zero/overflow done in 1 cycle.
// Backpressure: no handshake -- stall_o freezes the pipeline while RUN (or while a launch is accepted).
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i, funct3_i     launch request (honoured in IDLE only) and RV32M op code
//   rs1_i, rs2_i, rd_i    operands and destination tag, captured at launch
//   flush_i               abort the in-flight operation / discard a same-cycle launch
//   stall_o               combinational pipeline stall
//   done_o                one-cycle result-valid pulse
//   result_o, rd_o        registered result and destination tag
//   busy_o                high whenever the unit is not IDLE
module rv32m_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o,
   output logic            busy_o
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q;
   logic [2:0]      f3_q;
   logic            neg_q;
   logic [XLEN-1:0] acc_q;     // upper product half / partial remainder
   logic [XLEN-1:0] lo_q;      // multiplier (shifting out) / dividend-quotient
   logic [XLEN-1:0] opb_q;     // |multiplicand| or |divisor|
   logic [4:0]      rd_pend_q;

   // ---------------- launch-time operand preparation ----------------
   logic            is_div, sgn_a, sgn_b, a_neg, b_neg;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            div_zero, div_ovf, special, launch, last;
   logic [XLEN-1:0] special_res;

   always_comb begin
      is_div   = funct3_i[2];
      // MUL/MULH/MULHSU treat rs1 as signed; MUL/MULH also rs2; DIV/REM both.
      sgn_a    = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
      sgn_b    = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
      a_neg    = sgn_a & rs1_i[XLEN-1];
      b_neg    = sgn_b & rs2_i[XLEN-1];
      a_abs    = a_neg ? -rs1_i : rs1_i;
      b_abs    = b_neg ? -rs2_i : rs2_i;
      div_zero = is_div & (rs2_i == '0);
      div_ovf  = is_div & ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
      special  = div_zero | div_ovf;
      // Zero divisor: quotient all ones, remainder = dividend.
      // Overflow: quotient = dividend (most-negative), remainder 0.
      if (div_zero) special_res = funct3_i[1] ? rs1_i : '1;
      else          special_res = funct3_i[1] ? '0 : rs1_i;
   end

   assign launch = (state_q == IDLE) & start_i & ~flush_i;
   assign last   = (count_q == CW'(XLEN-1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      stall_o = 1'b0;
      done_o  = 1'b0;
      busy_o  = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            stall_o = start_i;
            if (launch) state_d = special ? DONE : RUN;
         end
         RUN: begin
            stall_o = 1'b1;
            if (flush_i)   state_d = IDLE;
            else if (last) state_d = DONE;
         end
         DONE: begin
            // A redirect in the DONE cycle withdraws the write-back.
            done_o  = ~flush_i;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- one radix-2 step ----------------
   logic [XLEN:0]     mul_sum, rem_sh;
   logic [XLEN-1:0]   div_diff, acc_d, lo_d;
   logic              div_ge;
   logic [2*XLEN-1:0] product, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

   always_comb begin
      mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      rem_sh   = {acc_q, lo_q[XLEN-1]};
      div_ge   = (rem_sh >= {1'b0, opb_q});
      // When the subtraction is kept the remainder is below the divisor, so XLEN bits suffice.
      div_diff = XLEN'(rem_sh - {1'b0, opb_q});
      if (f3_q[2]) begin
         acc_d = div_ge ? div_diff : rem_sh[XLEN-1:0];
         lo_d  = {lo_q[XLEN-2:0], div_ge};
      end else begin
         acc_d = mul_sum[XLEN:1];
         lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      product  = {acc_d, lo_d};
      prod_fix = neg_q ? -product : product;
      quot_fix = neg_q ? -lo_d : lo_d;
      rem_fix  = neg_q ? -acc_d : acc_d;
      if (f3_q[2])              final_res = f3_q[1] ? rem_fix : quot_fix;
      else if (f3_q[1:0] == 2'b00) final_res = prod_fix[XLEN-1:0];
      else                      final_res = prod_fix[2*XLEN-1:XLEN];
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q   <= '0;
         f3_q      <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         lo_q      <= '0;
         opb_q     <= '0;
         rd_pend_q <= '0;
         result_o  <= '0;
         rd_o      <= '0;
      end else if (launch) begin
         f3_q      <= funct3_i;
         // Remainder follows the dividend; product and quotient follow sA ^ sB.
         neg_q     <= (is_div & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
         acc_q     <= '0;
         lo_q      <= a_abs;
         opb_q     <= b_abs;
         count_q   <= '0;
         rd_pend_q <= rd_i;
         if (special) begin
            result_o <= special_res;
            rd_o     <= rd_i;
         end
      end else if (state_q == RUN && !flush_i) begin
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         count_q <= count_q + 1'b1;
         if (last) begin
            result_o <= final_res;
            rd_o     <= rd_pend_q;
         end
      end
   end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
module tb_rv32m_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset_i, start_i, flush_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_i, rs2_i;
   logic [4:0]  rd_i;
   logic        stall_o, done_o, busy_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   rv32m_muldiv_unit #(.XLEN(32)) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .funct3_i(funct3_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
      .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p, ua64, ub64;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ub   = longint'({32'd0, b});
      ua64 = {32'd0, a};
      ub64 = {32'd0, b};
      case (f)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = ua64 * ub64;  return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            p = 64'(sa / sb); return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFFFFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            p = 64'(sa % sb); return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   // phase: 0 idle, 1 computing (stalls), 2 result cycle
   int          m_phase = 0;
   int          m_left  = 0;
   logic [31:0] m_res = 0, m_pres = 0;
   logic [4:0]  m_rd = 0, m_prd = 0;
   bit          chk_en = 0;
   int          exp_dones = 0, dut_dones = 0;

   always begin
      @(negedge clk);
      #2;
      if (chk_en) begin
         check("done_o", done_o, (m_phase == 2 && !flush_i));
         check("busy_o", busy_o, (m_phase != 0));
         check("stall_o", stall_o, ((start_i && m_phase == 0) || m_phase == 1));
         check("result_o", result_o, m_res);
         check("rd_o", rd_o, m_rd);
         if (m_phase == 2 && !flush_i) exp_dones++;
         if (done_o) dut_dones++;
      end
      if (reset_i) begin
         m_phase = 0; m_res = 0; m_rd = 0; chk_en = 1;
      end else begin
         case (m_phase)
            0: if (start_i && !flush_i) begin
               if (is_special(funct3_i, rs1_i, rs2_i)) begin
                  m_phase = 2;
                  m_res   = ref_result(funct3_i, rs1_i, rs2_i);
                  m_rd    = rd_i;
               end else begin
                  m_phase = 1;
                  m_left  = 32;
                  m_pres  = ref_result(funct3_i, rs1_i, rs2_i);
                  m_prd   = rd_i;
               end
            end
            1: if (flush_i) m_phase = 0;
               else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase = 2; m_res = m_pres; m_rd = m_prd;
                  end
               end
            default: m_phase = 0;
         endcase
      end
   end

   // ---------------- directed helper ----------------
   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp, input int exp_lat);
      int n;
      check({"model ", name}, ref_result(f, a, b), exp);
      @(negedge clk);
      start_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b; rd_i = tag;
      @(negedge clk);
      start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
      n = 1;
      while (n <= 40) begin
         #3;
         if (done_o) break;
         @(negedge clk);
         n++;
      end
      check({"latency ", name}, n, exp_lat);
      check({"result ", name}, result_o, exp);
      check({"rd ", name}, rd_o, tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      reset_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      funct3_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
      repeat (3) @(negedge clk);
      #3;
      check("reset result", result_o, 32'd0);
      check("reset rd", rd_o, 5'd0);
      check("reset busy", busy_o, 1'b0);
      check("reset done", done_o, 1'b0);
      reset_i = 1'b0;

      run_op("MUL 7*-3",      3'd0, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33);
      run_op("MULH min*min",  3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 33);
      run_op("MULHSU -1*max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 33);
      run_op("MULHU max*max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 33);
      run_op("DIV -7/2",      3'd4, 32'hFFFFFFF9, 32'd2,        5'd5, 32'hFFFFFFFD, 33);
      run_op("REM -7/2",      3'd6, 32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFF, 33);
      run_op("DIVU 100/7",    3'd5, 32'd100,      32'd7,        5'd7, 32'd14,       33);
      run_op("REMU 100/7",    3'd7, 32'd100,      32'd7,        5'd8, 32'd2,        33);
      run_op("MUL 0*5",       3'd0, 32'd0,        32'd5,        5'd0, 32'd0,        33);
      run_op("DIVU 5/0",      3'd5, 32'd5,        32'd0,        5'd9, 32'hFFFFFFFF, 1);
      run_op("REM 5/0",       3'd6, 32'd5,        32'd0,        5'd10, 32'd5,       1);
      run_op("DIV ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
      run_op("REM ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,       1);

      // Flush a DIVU at cycle 10, relaunch MUL 3*4 at cycle 11.
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd7; rd_i = 5'd13;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (i == 10) flush_i = 1'b1;
      end
      @(negedge clk);
      flush_i = 1'b0;
      start_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4; rd_i = 5'd14;
      #3;
      check("busy after flush", busy_o, 1'b0);
      @(negedge clk);
      start_i = 1'b0;
      n = 1;
      while (n <= 40) begin
         #3;
         if (done_o) break;
         @(negedge clk);
         n++;
      end
      check("latency MUL after flush", n, 33);
      check("result MUL 3*4", result_o, 32'd12);
      check("rd MUL 3*4", rd_o, 5'd14);

      // Reset at cycle 20 of a multiply.
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'h1234; rs2_i = 32'h10; rd_i = 5'd15;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (i == 20) reset_i = 1'b1;
      end
      @(negedge clk);
      reset_i = 1'b0;
      #3;
      check("mid reset result", result_o, 32'd0);
      check("mid reset rd", rd_o, 5'd0);
      check("mid reset busy", busy_o, 1'b0);
      check("mid reset done", done_o, 1'b0);

      // start_i held high, rd_i alternating every cycle.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start_i  = 1'b1;
         rd_i     = (i % 2 == 0) ? 5'd5 : 5'd10;
         funct3_i = 3'($urandom_range(0, 7));
         rs1_i    = rand_operand();
         rs2_i    = rand_operand();
      end

      // Fully random traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start_i  = ($urandom_range(0, 1) == 1);
         flush_i  = ($urandom_range(0, 39) == 0);
         reset_i  = ($urandom_range(0, 299) == 0);
         funct3_i = 3'($urandom_range(0, 7));
         rs1_i    = rand_operand();
         rs2_i    = rand_operand();
         rd_i     = 5'($urandom);
      end

      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0; reset_i = 1'b0;
      repeat (40) @(negedge clk);
      #3;
      check("done pulse count", dut_dones, exp_dones);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32m_muldiv_unit.md
# rv32m_muldiv_unit

Iterative RV32M multiply/divide unit that sits beside the execute stage and feeds the memory stage's multiplier-result path (`mul_read`) into write-back. It accepts operands from execute and produces one 32-bit result per operation after a fixed iterative latency. Division by zero and signed overflow are resolved early. While busy it drives the pipeline-wide stall.

## Interface
- `XLEN`, 32: operand/result width. Only 32 is supported.
- `clk_i` input 1: clock. Single clock domain.
- `reset_i` input 1: synchronous, active-high reset.
- `start_i` input 1: launch request. Sampled only when `state==IDLE`.
- `funct3_i` input 3: operation code.
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `rs1_i` input 32: operand A (multiplicand/dividend).
- `rs2_i` input 32: operand B (multiplier/divisor).
- `rd_i` input 5: destination register tag, captured at launch.
- `flush_i` input 1: abort the in-flight operation (branch redirect).
- `stall_o` output 1: pipeline stall, combinational. Equals `(start_i & IDLE) | RUN`.
- `done_o` output 1: one-cycle pulse; `result_o` and `rd_o` are valid.
- `result_o` output 32: registered result.
- `rd_o` output 5: registered destination tag.
- `busy_o` output 1: registered; high whenever `state != IDLE`.

## Operation
States:
- IDLE:
  - `start_i=1` captures operands, `funct3`, and `rd`.
  - Special case detected → DONE.
  - Otherwise → RUN, with `count=0`.
- RUN: one radix-2 iteration per cycle.
  - `count` increments each cycle.
  - At `count==31`, the final corrected result is registered and the state → DONE.
- DONE: `done_o=1` for exactly one cycle, then → IDLE. `start_i` is ignored in DONE.

Operand preparation at launch:
- Signed operands are converted to absolute values. Sign rules:
  - MUL/MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
- Result sign:
  - Product: `neg = sA ^ sB`.
  - Quotient: `neg = sA ^ sB`.
  - Remainder: takes the sign of the dividend (`sA`).

Multiply:
- Shift-add over a 64-bit accumulator.
- The final two's-complement negate is applied over the full 64 bits.
- MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].

Divide:
- Restoring division on a 33-bit partial remainder; one quotient bit per cycle, MSB first.

Special cases (resolved in IDLE, go straight to DONE, skip RUN):
- Divisor 0:
  - DIV/DIVU → `0xFFFFFFFF`.
  - REM/REMU → rs1 unchanged.
- Signed overflow (DIV/REM with rs1=`0x80000000`, rs2=`0xFFFFFFFF`):
  - DIV → `0x80000000`.
  - REM → `0`.
- No early-out for multiply; operand 0 still takes 32 iterations.

Flush, reset, and input handling:
- `flush_i` in RUN or DONE:
  - Next state IDLE.
  - `done_o` is suppressed in that cycle and the next.
  - `result_o` and `rd_o` keep their old values.
- `flush_i` in IDLE together with `start_i`: the launch is discarded.
- `reset_i`: state IDLE, `count=0`, `result_o=0`, `rd_o=0`, `done_o=0`, `busy_o=0`. Applies mid-operation too; reset has priority over flush and start.
- `rs1_i`/`rs2_i` changing after launch has no effect; operands are held internally.
- `rd=0` is passed through unchanged; write-back drops it.

## Timing
- Cycle 0 is the cycle in which `start_i=1` is sampled in IDLE. `stall_o=1` in cycle 0.
- Normal operation:
  - RUN occupies cycles 1–32; `stall_o=1` and `busy_o=1` throughout.
  - DONE is cycle 33: `done_o=1`, result valid, `stall_o=0`, `busy_o=1`.
  - IDLE resumes at cycle 34.
- Special case: DONE in cycle 1; `stall_o=1` only in cycle 0.
- Back-to-back throughput: the earliest next `start_i` accepted is cycle 34 (normal) or cycle 2 (special case).
- Outputs change only on `clk_i` rising edges, except `stall_o`.

## Test plan
- MUL rs1=7, rs2=−3 (`0xFFFFFFFD`):
  - `done_o` in cycle 33 with `result_o=0xFFFFFFEB`.
  - `stall_o` high in cycles 0–32.
- MULH `0x80000000`×`0x80000000` → `0x40000000`.
- MULHSU rs1=−1, rs2=`0xFFFFFFFF` → `0xFFFFFFFF`.
- MULHU `0xFFFFFFFF`×`0xFFFFFFFF` → `0xFFFFFFFE`.
- DIV −7/2 → `0xFFFFFFFD`; REM −7/2 → `0xFFFFFFFF`; DIVU 100/7 → 14; REMU 100/7 → 2. Each has `done_o` in cycle 33.
- Special cases:
  - DIVU 5/0 → `0xFFFFFFFF`, `done_o` in cycle 1.
  - REM 5/0 → 5.
  - DIV `0x80000000`/−1 → `0x80000000`.
  - REM `0x80000000`/−1 → 0. Each has `done_o` in cycle 1.
- Flush and reset mid-operation:
  - `flush_i` at cycle 10 of a DIVU: no `done_o`, `busy_o=0` from cycle 11.
  - A new MUL 3×4 launched at cycle 11 → 12 in cycle 44.
  - `reset_i` at cycle 20 → all outputs 0 next cycle.
- `start_i` held high continuously with `rd_i` alternating: each accepted op yields exactly one `done_o`, with `rd_o` matching the launch-cycle tag. No launches occur in RUN or DONE.
